// File: rtl/lname_mbus_member_ctrl_if.sv
// Controller-side companion to the MBus member controller: synchronizes and arbitrates
// EXTERNAL_INT, sequences short-prefix writes/invalidates with read-back, and issues SLEEP_REQ.
module lname_mbus_member_ctrl_if #(
    parameter int SYNC_STAGES = 2,
    parameter int WR_PULSE    = 2,
    parameter int SLEEP_DELAY = 4,
    parameter int CLR_TIMEOUT = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       external_int_i,
    output logic       clr_ext_int_o,
    output logic       int_req_o,
    input  logic       int_ack_i,
    input  logic       enum_valid_i,
    input  logic [3:0] enum_addr_i,
    input  logic       inval_req_i,
    input  logic       sleep_cmd_i,
    output logic       addr_wr_en_o,
    output logic [3:0] addr_in_o,
    output logic       addr_clr_b_o,
    input  logic [3:0] addr_out_i,
    input  logic       addr_valid_i,
    output logic       sleep_req_o,
    output logic       cmd_done_o,
    output logic       cmd_err_o,
    output logic       busy_o
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_INT_CLR,
        S_ADDR_SETUP,
        S_ADDR_WR,
        S_ADDR_HOLD,
        S_ADDR_CHK,
        S_INVAL,
        S_INVAL_CHK,
        S_SLEEP_WAIT,
        S_SLEEP
    } state_t;

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [3:0]             addrIn_q, addrIn_d;
    logic                   intPending_q, intPending_d;
    logic [SYNC_STAGES-1:0] syncChain_q;
    logic                   intSPrev_q;
    logic                   cmdDone_d, cmdErr_d;
    logic                   clrExtInt_q, intReq_q, addrWrEn_q, addrClrB_q;
    logic                   sleepReq_q, cmdDone_q, cmdErr_q, busy_q;

    logic intS, intRise, anyCmd, enumReserved, enumMatch, invalMatch;

    assign intS         = syncChain_q[SYNC_STAGES-1];
    assign intRise      = intS & ~intSPrev_q;
    assign anyCmd       = sleep_cmd_i | inval_req_i | enum_valid_i;
    assign enumReserved = (enum_addr_i == 4'h0) || (enum_addr_i == 4'hF);
    assign enumMatch    = addr_valid_i && (addr_out_i == addrIn_q);
    assign invalMatch   = !addr_valid_i && (addr_out_i == 4'hF);

    // Read-back checks sample during the cycle before the result state so the pulse is registered.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addrIn_d     = addrIn_q;
        intPending_d = intPending_q | intRise;
        cmdDone_d    = 1'b0;
        cmdErr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sleep_cmd_i) begin
                    state_d  = S_SLEEP_WAIT;
                    cnt_d    = 8'(SLEEP_DELAY - 1);
                    cmdErr_d = inval_req_i | enum_valid_i;
                end else if (inval_req_i) begin
                    state_d  = S_INVAL;
                    cnt_d    = 8'(WR_PULSE - 1);
                    cmdErr_d = enum_valid_i;
                end else if (enum_valid_i) begin
                    if (enumReserved) begin
                        cmdErr_d = 1'b1;
                    end else begin
                        state_d  = S_ADDR_SETUP;
                        addrIn_d = enum_addr_i;
                    end
                end else if (int_ack_i && intPending_q) begin
                    state_d = S_INT_CLR;
                    cnt_d   = 8'(CLR_TIMEOUT - 1);
                end
            end
            S_ADDR_SETUP: begin
                state_d  = S_ADDR_WR;
                cnt_d    = 8'(WR_PULSE - 1);
                cmdErr_d = anyCmd;
            end
            S_ADDR_WR: begin
                if (cnt_q == 8'd0) state_d = S_ADDR_HOLD;
                else               cnt_d   = cnt_q - 8'd1;
                cmdErr_d = anyCmd;
            end
            S_ADDR_HOLD: begin
                state_d   = S_ADDR_CHK;
                cmdDone_d = enumMatch;
                cmdErr_d  = !enumMatch | anyCmd;
            end
            S_ADDR_CHK: begin
                state_d  = S_IDLE;
                cmdErr_d = anyCmd;
            end
            S_INVAL: begin
                if (cnt_q == 8'd0) begin
                    state_d   = S_INVAL_CHK;
                    cmdDone_d = invalMatch;
                    cmdErr_d  = !invalMatch;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
                cmdErr_d = cmdErr_d | anyCmd;
            end
            S_INVAL_CHK: begin
                state_d  = S_IDLE;
                cmdErr_d = anyCmd;
            end
            S_INT_CLR: begin
                if (!intS) begin
                    state_d      = S_IDLE;
                    intPending_d = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    state_d  = S_IDLE;
                    cmdErr_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
                cmdErr_d = cmdErr_d | anyCmd;
            end
            S_SLEEP_WAIT: begin
                if (cnt_q == 8'd0) state_d = S_SLEEP;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_SLEEP: state_d = S_SLEEP;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 8'd0;
            addrIn_q     <= 4'h0;
            intPending_q <= 1'b0;
            syncChain_q  <= '0;
            intSPrev_q   <= 1'b0;
            clrExtInt_q  <= 1'b0;
            intReq_q     <= 1'b0;
            addrWrEn_q   <= 1'b0;
            addrClrB_q   <= 1'b1;
            sleepReq_q   <= 1'b0;
            cmdDone_q    <= 1'b0;
            cmdErr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addrIn_q     <= addrIn_d;
            intPending_q <= intPending_d;
            syncChain_q  <= {syncChain_q[SYNC_STAGES-2:0], external_int_i};
            intSPrev_q   <= intS;
            clrExtInt_q  <= (state_d == S_INT_CLR);
            intReq_q     <= intPending_d && (state_d != S_INT_CLR);
            addrWrEn_q   <= (state_d == S_ADDR_WR);
            addrClrB_q   <= (state_d != S_INVAL);
            sleepReq_q   <= (state_d == S_SLEEP);
            cmdDone_q    <= cmdDone_d;
            cmdErr_q     <= cmdErr_d;
            busy_q       <= (state_d != S_IDLE);
        end
    end

    assign clr_ext_int_o = clrExtInt_q;
    assign int_req_o     = intReq_q;
    assign addr_wr_en_o  = addrWrEn_q;
    assign addr_in_o     = addrIn_q;
    assign addr_clr_b_o  = addrClrB_q;
    assign sleep_req_o   = sleepReq_q;
    assign cmd_done_o    = cmdDone_q;
    assign cmd_err_o     = cmdErr_q;
    assign busy_o        = busy_q;

endmodule

// File: tb/tb_lname_mbus_member_ctrl_if.sv
// Bench for lname_mbus_member_ctrl_if: expected waveforms come from the command timing rules,
// with a small prefix-register model answering the read-back.
module tb_lname_mbus_member_ctrl_if;

    localparam int WP = 2;
    localparam int SD = 4;
    localparam int CT = 16;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       external_int_i = 1'b0;
    logic       int_ack_i = 1'b0;
    logic       enum_valid_i = 1'b0;
    logic [3:0] enum_addr_i = 4'h0;
    logic       inval_req_i = 1'b0;
    logic       sleep_cmd_i = 1'b0;
    logic [3:0] addr_out_i;
    logic       addr_valid_i;
    logic       clr_ext_int_o, int_req_o, addr_wr_en_o, addr_clr_b_o;
    logic [3:0] addr_in_o;
    logic       sleep_req_o, cmd_done_o, cmd_err_o, busy_o;

    logic [3:0] prefixModel = 4'hF;
    logic       validModel = 1'b0;
    logic       corrupt = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lname_mbus_member_ctrl_if #(
        .SYNC_STAGES(2), .WR_PULSE(WP), .SLEEP_DELAY(SD), .CLR_TIMEOUT(CT)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .external_int_i(external_int_i),
        .clr_ext_int_o(clr_ext_int_o), .int_req_o(int_req_o), .int_ack_i(int_ack_i),
        .enum_valid_i(enum_valid_i), .enum_addr_i(enum_addr_i), .inval_req_i(inval_req_i),
        .sleep_cmd_i(sleep_cmd_i), .addr_wr_en_o(addr_wr_en_o), .addr_in_o(addr_in_o),
        .addr_clr_b_o(addr_clr_b_o), .addr_out_i(addr_out_i), .addr_valid_i(addr_valid_i),
        .sleep_req_o(sleep_req_o), .cmd_done_o(cmd_done_o), .cmd_err_o(cmd_err_o),
        .busy_o(busy_o)
    );

    // Member-controller prefix register; corrupt flips the read-back LSB to force a check failure.
    always @(posedge clk) begin
        if (addr_wr_en_o === 1'b1) begin
            prefixModel <= addr_in_o;
            validModel  <= 1'b1;
        end else if (addr_clr_b_o === 1'b0) begin
            prefixModel <= 4'hF;
            validModel  <= 1'b0;
        end
    end
    assign addr_out_i   = prefixModel ^ {3'b000, corrupt};
    assign addr_valid_i = validModel;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sleepV, input logic invalV, input logic enumV,
                                 input logic [3:0] addr, input logic ackV);
        sleep_cmd_i  = sleepV;
        inval_req_i  = invalV;
        enum_valid_i = enumV;
        enum_addr_i  = addr;
        int_ack_i    = ackV;
    endtask

    // Enumerate from IDLE; injectAt>0 pulses a second ENUM_VALID in that cycle of the sequence.
    task automatic runEnum(input logic [3:0] addr, input logic bad, input int injectAt);
        logic reserved;
        logic expWr, expDone, expErr, expBusy;
        reserved = (addr == 4'h0) || (addr == 4'hF);
        corrupt  = bad;
        applyStimulus(1'b0, 1'b0, 1'b1, addr, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int k = 1; k <= 4 + WP; k++) begin
            expWr   = !reserved && (k >= 2) && (k <= 1 + WP);
            expDone = !reserved && !bad && (k == 3 + WP);
            expErr  = (reserved && k == 1) || (!reserved && bad && k == 3 + WP)
                      || (injectAt != 0 && k == injectAt + 1);
            expBusy = !reserved && (k >= 1) && (k <= 3 + WP);
            checkOutput($sformatf("enum%0h wr_en k=%0d", addr, k), 8'(addr_wr_en_o), 8'(expWr));
            checkOutput($sformatf("enum%0h done k=%0d", addr, k), 8'(cmd_done_o), 8'(expDone));
            checkOutput($sformatf("enum%0h err k=%0d", addr, k), 8'(cmd_err_o), 8'(expErr));
            checkOutput($sformatf("enum%0h busy k=%0d", addr, k), 8'(busy_o), 8'(expBusy));
            if (!reserved && k == 1)
                checkOutput("enum addr_in", 8'(addr_in_o), 8'(addr));
            enum_valid_i = (injectAt != 0 && k == injectAt);
            enum_addr_i  = 4'h3;
            step();
        end
        enum_valid_i = 1'b0;
        corrupt      = 1'b0;
    endtask

    task automatic runInval(input logic bad);
        corrupt = bad;
        applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int k = 1; k <= 3 + WP; k++) begin
            checkOutput($sformatf("inval clr_b k=%0d", k), 8'(addr_clr_b_o),
                        8'(!((k >= 1) && (k <= WP))));
            checkOutput($sformatf("inval done k=%0d", k), 8'(cmd_done_o), 8'(!bad && k == WP + 1));
            checkOutput($sformatf("inval err k=%0d", k), 8'(cmd_err_o), 8'(bad && k == WP + 1));
            checkOutput($sformatf("inval busy k=%0d", k), 8'(busy_o), 8'(k <= WP + 1));
            step();
        end
        corrupt = 1'b0;
    endtask

    task automatic waitIntReq(input string tag);
        int lat;
        lat = 0;
        while (int_req_o !== 1'b1 && lat < 8) begin
            step();
            lat++;
        end
        checkOutput({tag, " int_req"}, 8'(int_req_o), 8'd1);
        checkOutput({tag, " latency<=4"}, 8'(lat <= 4), 8'd1);
    endtask

    // Acknowledge and wait for the clear handshake to finish; errSeen reports any CMD_ERR pulse.
    task automatic ackAndDrain(input string tag, input int dropAfter);
        int n;
        logic errSeen;
        errSeen = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        step();
        int_ack_i = 1'b0;
        checkOutput({tag, " clr_ext_int"}, 8'(clr_ext_int_o), 8'd1);
        checkOutput({tag, " int_req in clr"}, 8'(int_req_o), 8'd0);
        n = 0;
        while (clr_ext_int_o === 1'b1 && n < 12) begin
            if (n == dropAfter) external_int_i = 1'b0;
            step();
            errSeen = errSeen | (cmd_err_o === 1'b1);
            n++;
        end
        checkOutput({tag, " clr dropped"}, 8'(clr_ext_int_o), 8'd0);
        checkOutput({tag, " int_req cleared"}, 8'(int_req_o), 8'd0);
        checkOutput({tag, " no err"}, 8'(errSeen), 8'd0);
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        reset_i = 1'b1;
        step();
        step();
        checkOutput("rst clr_ext_int", 8'(clr_ext_int_o), 8'd0);
        checkOutput("rst int_req", 8'(int_req_o), 8'd0);
        checkOutput("rst wr_en", 8'(addr_wr_en_o), 8'd0);
        checkOutput("rst addr_in", 8'(addr_in_o), 8'd0);
        checkOutput("rst clr_b", 8'(addr_clr_b_o), 8'd1);
        checkOutput("rst sleep_req", 8'(sleep_req_o), 8'd0);
        checkOutput("rst done", 8'(cmd_done_o), 8'd0);
        checkOutput("rst err", 8'(cmd_err_o), 8'd0);
        checkOutput("rst busy", 8'(busy_o), 8'd0);
        reset_i = 1'b0;
        step();

        runEnum(4'h5, 1'b0, 0);
        runEnum(4'hF, 1'b0, 0);
        runInval(1'b0);

        for (int i = 0; i < 16; i++) begin
            int op;
            logic bad;
            op  = $urandom_range(0, 3);
            bad = ($urandom_range(0, 4) == 0);
            if (op < 3) runEnum(4'($urandom_range(0, 15)), bad, 0);
            else        runInval(bad);
            repeat ($urandom_range(0, 2)) step();
        end

        external_int_i = 1'b1;
        waitIntReq("int1");
        ackAndDrain("int1", 3);
        checkOutput("int1 idle", 8'(busy_o), 8'd0);

        external_int_i = 1'b1;
        waitIntReq("int2");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b1);
        step();
        int_ack_i = 1'b0;
        for (int k = 1; k <= CT + 1; k++) begin
            checkOutput($sformatf("stuck clr k=%0d", k), 8'(clr_ext_int_o), 8'(k <= CT));
            checkOutput($sformatf("stuck err k=%0d", k), 8'(cmd_err_o), 8'(k == CT + 1));
            checkOutput($sformatf("stuck int_req k=%0d", k), 8'(int_req_o), 8'(k == CT + 1));
            if (k <= CT) step();
        end
        external_int_i = 1'b0;
        repeat (3) step();
        checkOutput("stuck pending kept", 8'(int_req_o), 8'd1);
        ackAndDrain("int3", 0);

        runEnum(4'($urandom_range(1, 14)), 1'b0, 2);

        applyStimulus(1'b0, 1'b0, 1'b1, 4'h9, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        step();
        checkOutput("rstmid wr_en before", 8'(addr_wr_en_o), 8'd1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        checkOutput("rstmid wr_en", 8'(addr_wr_en_o), 8'd0);
        checkOutput("rstmid busy", 8'(busy_o), 8'd0);
        checkOutput("rstmid clr_b", 8'(addr_clr_b_o), 8'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("rstmid no done %0d", k), 8'(cmd_done_o), 8'd0);
            step();
        end

        applyStimulus(1'b1, 1'b0, 1'b1, 4'h3, 1'b1);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int k = 1; k <= SD + 1; k++) begin
            checkOutput($sformatf("sleep req k=%0d", k), 8'(sleep_req_o), 8'(k == SD + 1));
            checkOutput($sformatf("sleep err k=%0d", k), 8'(cmd_err_o), 8'(k == 1));
            checkOutput($sformatf("sleep wr_en k=%0d", k), 8'(addr_wr_en_o), 8'd0);
            if (k <= SD) step();
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 4'h6, 1'b0);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("asleep err %0d", k), 8'(cmd_err_o), 8'd0);
            checkOutput($sformatf("asleep done %0d", k), 8'(cmd_done_o), 8'd0);
            checkOutput($sformatf("asleep req %0d", k), 8'(sleep_req_o), 8'd1);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lname_mbus_member_ctrl_if.md
# lname_mbus_member_ctrl_if

Controller-side companion to the MBus member controller: runs in the power-gated MBus controller domain, directly downstream of the member controller's interrupt output and upstream of its short-prefix register and sleep inputs. It synchronizes EXTERNAL_INT, arbitrates it to the bus controller and completes the CLR_EXT_INT handshake. It also sequences short-prefix writes and invalidates with read-back checking, and issues SLEEP_REQ after a drain delay.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for EXTERNAL_INT (min 2).
- WR_PULSE, 2: cycles ADDR_WR_EN / ADDR_CLR_B are active (1..15).
- SLEEP_DELAY, 4: cycles between SLEEP_CMD and SLEEP_REQ (1..15).
- CLR_TIMEOUT, 16: maximum cycles in INT_CLR (2..255).

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  controller clock; all state on rising edge.
- RESET  in  1  synchronous active-high reset.
- EXTERNAL_INT  in  1  asynchronous interrupt from the member controller.
- CLR_EXT_INT  out  1  interrupt clear to the member controller.
- INT_REQ  out  1  interrupt pending; request to the bus controller.
- INT_ACK  in  1  bus controller grants interrupt service (1-cycle pulse).
- ENUM_VALID  in  1  assign-prefix command (1-cycle pulse).
- ENUM_ADDR  in  4  prefix to assign; sampled with ENUM_VALID.
- INVAL_REQ  in  1  invalidate-prefix command (1-cycle pulse).
- SLEEP_CMD  in  1  sleep command (1-cycle pulse).
- ADDR_WR_EN  out  1  prefix write strobe.
- ADDR_IN  out  4  prefix data.
- ADDR_CLR_B  out  1  prefix clear, active-low.
- ADDR_OUT  in  4  prefix read-back.
- ADDR_VALID  in  1  prefix-valid read-back.
- SLEEP_REQ  out  1  sleep request to the member controller.
- CMD_DONE  out  1  command completed OK (1-cycle pulse).
- CMD_ERR  out  1  command rejected or failed (1-cycle pulse).
- BUSY  out  1  FSM not in IDLE.

## Operation
- All outputs are registered Moore decodes. Reset values: CLR_EXT_INT=0, INT_REQ=0, ADDR_WR_EN=0, ADDR_IN=0, ADDR_CLR_B=1, SLEEP_REQ=0, CMD_DONE=0, CMD_ERR=0, BUSY=0. The FSM resets to IDLE, int_pending=0 and the synchronizer to 0.
- Synchronizer: EXTERNAL_INT passes through SYNC_STAGES flops to give int_s. A rising edge of int_s sets int_pending. INT_REQ = int_pending and state is not INT_CLR.
- FSM states: IDLE, INT_CLR, ADDR_SETUP, ADDR_WR, ADDR_HOLD, ADDR_CHK, INVAL, INVAL_CHK, SLEEP_WAIT, SLEEP.
- IDLE priority when events coincide: SLEEP_CMD > INVAL_REQ > ENUM_VALID > INT_ACK. INT_ACK is accepted only while int_pending=1 and is ignored otherwise. A lower-priority command in the same cycle is dropped and raises CMD_ERR on the next cycle.
- ENUM:
  - ENUM_ADDR is latched.
  - 4'h0 and 4'hF are reserved: CMD_ERR is raised on the next cycle, no write occurs, and the FSM stays in IDLE.
  - Otherwise the sequence is ADDR_SETUP (1 cycle, ADDR_IN valid) → ADDR_WR (WR_PULSE cycles, ADDR_WR_EN=1) → ADDR_HOLD (1 cycle, ADDR_IN held) → ADDR_CHK.
  - ADDR_CHK raises CMD_DONE if ADDR_VALID=1 and ADDR_OUT equals the latch, else CMD_ERR, then returns to IDLE.
  - ADDR_IN holds its value until the next ENUM.
- INVAL: INVAL (WR_PULSE cycles, ADDR_CLR_B=0) → INVAL_CHK. INVAL_CHK raises CMD_DONE if ADDR_VALID=0 and ADDR_OUT=4'hF, else CMD_ERR.
- INT_CLR:
  - CLR_EXT_INT=1.
  - When int_s=0 is observed, the FSM returns to IDLE next cycle, CLR_EXT_INT drops and int_pending clears.
  - If CLR_TIMEOUT cycles elapse first, the FSM returns to IDLE, CLR_EXT_INT drops, CMD_ERR pulses and int_pending stays set.
- SLEEP: SLEEP_WAIT counts SLEEP_DELAY cycles, then the FSM enters SLEEP with SLEEP_REQ=1. SLEEP is terminal; only RESET exits it. Commands are ignored in SLEEP_WAIT and SLEEP without error.
- Commands arriving in any other non-IDLE state are dropped with a CMD_ERR pulse.
- Counters are 8 bits, load on state entry and count down. There is no wrap-around.

## Timing
- ENUM_VALID at cycle N (IDLE): ADDR_SETUP at N+1; ADDR_WR_EN high N+2..N+1+WR_PULSE; ADDR_HOLD at N+2+WR_PULSE; CMD_DONE/CMD_ERR at N+3+WR_PULSE; IDLE at N+4+WR_PULSE. With WR_PULSE=2, CMD_DONE is at N+5.
- INVAL_REQ at N: ADDR_CLR_B low N+1..N+WR_PULSE; result pulse at N+WR_PULSE+1.
- SLEEP_CMD at N: SLEEP_REQ rises at N+SLEEP_DELAY+1.
- EXTERNAL_INT rise to INT_REQ: SYNC_STAGES+1 cycles, +1 for asynchronous sampling.
- INT_ACK at M: CLR_EXT_INT is high from M+1.
- RESET asserted in any state forces reset values at the next edge: ADDR_WR_EN and ADDR_CLR_B return inactive immediately and a pending result pulse is suppressed.

## Test plan
- Enumerate with ENUM_ADDR=4'h5 and the model returning ADDR_OUT=5, ADDR_VALID=1 → ADDR_WR_EN high at N+2..N+3, CMD_DONE at N+5, BUSY low at N+6.
- Enumerate with ENUM_ADDR=4'hF → no ADDR_WR_EN, CMD_ERR at N+1. Then INVAL_REQ with the model clearing to ADDR_OUT=F, ADDR_VALID=0 → ADDR_CLR_B low 2 cycles, CMD_DONE at N+3.
- EXTERNAL_INT rises → INT_REQ within 4 cycles. INT_ACK → CLR_EXT_INT=1; the model drops EXTERNAL_INT after 3 cycles → CLR_EXT_INT=0, INT_REQ=0. Repeat with EXTERNAL_INT stuck high → CMD_ERR after 16 cycles, INT_REQ reasserts.
- SLEEP_CMD, ENUM_VALID and INT_ACK in the same cycle → SLEEP_REQ at N+5, CMD_ERR at N+1; a later ENUM_VALID is ignored with no pulse.
- ENUM_VALID during ADDR_WR → CMD_ERR. RESET asserted mid-ADDR_WR → ADDR_WR_EN=0, BUSY=0 next edge, no CMD_DONE.
